mem_requester: RTL

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_requester_if.sv | 37 +++
 rtl/mem_requester.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_requester_if.sv
// Bundles the core request/response handshake and the MemController bus of one requester.
// Latency: none; this is wiring only.
// Backpressure: req_ready from the requester and acq from MemController are the only stall signals.
interface mem_requester_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // core side
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    // MemController side
    logic          rden;
    logic          wren;
    logic [AW-1:0] Address;
    logic [DW-1:0] Din;
    logic          acq;
    logic [DW-1:0] Dq;

    // requester view
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, acq, Dq,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rden, wren, Address, Din
    );

    // core + MemController view
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, acq, Dq,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rden, wren, Address, Din
    );
endinterface

// File: rtl/mem_requester.sv
// Single-outstanding memory requester: latches one core access and runs it against MemController.
// Latency: write 2 cycles, read 3 cycles from accept, plus one cycle per REQ cycle without acq.
// Backpressure: req_ready only in IDLE, no queueing; REQ holds until acq (or until TIMEOUT when
// REQ_TIMEOUT_EN is defined, which completes the access with rsp_err=1 and no memory effect).
module mem_requester #(
    parameter int         AW      = 8,
    parameter int         DW      = 8,
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic              clk,
    input  logic              rst,
    mem_requester_if.master   bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        RSP       = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // latched access; Address/Din double as the latched address and write data
    logic          we_l;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic          rden_q;
    logic          wren_q;
    logic          rden_nxt;
    logic          wren_nxt;

    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;

    logic          accept;
    logic          capture;

`ifdef REQ_TIMEOUT_EN
    logic [7:0]    tmo_cnt;
    logic [7:0]    tmo_cnt_inc;
    logic          tmo_hit;
    logic          rsp_err_q;

    assign tmo_cnt_inc = tmo_cnt + 8'd1;
`endif

    // state register; reset drops any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and next values of the registered MemController strobes
    always_comb begin
        state_nxt = state;
        rden_nxt  = rden_q;
        wren_nxt  = wren_q;
        accept    = 1'b0;
        capture   = 1'b0;
`ifdef REQ_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                    rden_nxt  = !bus.req_we;
                    wren_nxt  = bus.req_we;
                end
            end
            REQ: begin
                // acq wins over a timeout landing in the same cycle
                if (bus.acq) begin
                    if (we_l) begin
                        state_nxt = RSP;
                        wren_nxt  = 1'b0;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
`ifdef REQ_TIMEOUT_EN
                end else if (tmo_cnt_inc >= TIMEOUT) begin
                    state_nxt = RSP;
                    rden_nxt  = 1'b0;
                    wren_nxt  = 1'b0;
                    tmo_hit   = 1'b1;
`endif
                end
            end
            WAIT_DATA: begin
                // read data is taken on the way out, acq no longer matters
                capture   = 1'b1;
                state_nxt = RSP;
                rden_nxt  = 1'b0;
            end
            RSP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                rden_nxt  = 1'b0;
                wren_nxt  = 1'b0;
            end
        endcase
    end

    // registered bus outputs, request latch and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            we_l        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rden_q      <= rden_nxt;
            wren_q      <= wren_nxt;
            rsp_valid_q <= (state_nxt == RSP);
            if (accept) begin
                we_l   <= bus.req_we;
                addr_q <= bus.req_addr;
                din_q  <= bus.req_wdata;
            end
            if (capture) begin
                rsp_rdata_q <= bus.Dq;
            end
        end
    end

`ifdef REQ_TIMEOUT_EN
    // grant-wait counter: cleared on entry to REQ, counts REQ cycles without acq
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= 8'd0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= tmo_hit;
            if (accept) begin
                tmo_cnt <= 8'd0;
            end else if (state == REQ && !bus.acq) begin
                tmo_cnt <= tmo_cnt_inc;
            end
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.rden      = rden_q;
    assign bus.wren      = wren_q;
    assign bus.Address   = addr_q;
    assign bus.Din       = din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
